inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer side of the instruction-memory interface. The CPU only reads 16-bit words from instruction memory at PC/PC+2; this block fills that memory.
- Accepts a byte stream through a valid/ready handshake, typically from a UART receiver or keypad front-end.
- Assembles big-endian 16-bit words and writes them to consecutive word addresses.
- Verifies an XOR checksum and holds the CPU in reset for the whole load.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest accepted program length in words; must be <= 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle request to begin a load.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  incoming stream byte.
- byte_ready  output  1  block accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address for mem_wdata.
- mem_wdata  output  16  instruction word, {hi byte, lo byte}.
- cpu_hold  output  1  held high while loading; ORed into the CPU reset.
- done  output  1  load finished with a good checksum; sticky.
- error  output  1  load aborted; sticky.
- word_count  output  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset applies to all outputs and the internal checksum register:
  - state=IDLE.
  - byte_ready, mem_we, cpu_hold, done, error = 0.
  - mem_addr, mem_wdata, word_count = 0.
  - Internal checksum register = 0.
- Stream format: LEN_HI, LEN_LO (length N in words, big-endian), then N x {W_HI, W_LO}, then CHK.
  - CHK = XOR of every byte before it, including both length bytes.
- A byte is consumed only when byte_valid && byte_ready on a rising clk. byte_ready is combinationally 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK, and 0 otherwise.
- Throughput: one byte per cycle, with no bubbles.
- FSM states:
  - IDLE: load_start -> LEN_HI. Clear done, error, word_count and checksum. Set cpu_hold=1.
  - LEN_HI: on accept, latch len[15:8] -> LEN_LO.
  - LEN_LO: on accept, latch len[7:0], then:
    - N=0 -> CHECK.
    - N>MAX_WORDS -> ERR. Remaining bytes are not consumed.
    - otherwise -> DATA_HI.
  - DATA_HI: on accept, latch the hi byte -> DATA_LO.
  - DATA_LO: on accept, register a write. The next cycle has mem_we=1, mem_wdata={hi,lo} and mem_addr = current word index, then word_count increments.
    - More words remain -> DATA_HI.
    - Last word -> CHECK.
  - CHECK: on accept, compare byte_data with the running XOR.
    - Equal -> DONE.
    - Unequal -> ERR.
  - DONE: done=1, cpu_hold=0. load_start -> LEN_HI, same actions as from IDLE.
  - ERR: error=1, cpu_hold=1 (a CPU never runs a corrupt image). load_start -> LEN_HI, same actions as from IDLE.
- Write timing: latency is 1 cycle from the lo-byte accept to mem_we. mem_addr and mem_wdata are stable during the mem_we cycle. Back-to-back words give mem_we every 2nd cycle.
- Address: word index starts at 0 and increments after each write. It never wraps, because N<=MAX_WORDS<=2**ADDR_W.
- Boundary and precedence rules:
  - load_start outside IDLE/DONE/ERR is ignored.
  - byte_valid in IDLE/DONE/ERR is ignored and nothing is consumed.
  - reset mid-load aborts immediately to IDLE. Partial memory contents are left as written.
  - reset has priority over load_start in the same cycle.
  - load_start and byte_valid in the same cycle from IDLE: only the start is taken; the byte is not consumed.

Decomposition:
- Package inst_loader_pkg holds:
  - state encoding enum: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
  - stream field constants.
- Single module with no sub-module. The FSM, word assembler, checksum XOR and address counter are all small.

Test Plan:
1. Good load: start; bytes 00 02 12 34 AB CD then CHK 00^02^12^34^AB^CD=0x42 -> mem_we at addr 0 data 0x1234 and addr 1 data 0xABCD; done=1, cpu_hold=0, word_count=2.
2. Bad checksum: same stream with CHK=0x43 -> both words written, then error=1, cpu_hold stays 1, done=0.
3. Length too large with MAX_WORDS=256: bytes 01 01 -> ERR right after LEN_LO; byte_ready=0; no mem_we.
4. Zero length: 00 00 00 -> done=1, word_count=0, no mem_we.
5. Gapped stream: byte_valid toggled 1/0 during scenario 1 -> identical writes and result; no byte consumed while byte_valid=0.
6. Reset after 3 data bytes -> IDLE, all outputs 0. A following full good load from scenario 1 succeeds. Repeat load_start from DONE -> second load overwrites from addr 0.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and stream constants for the instruction-memory loader.
// The stream is LEN_HI, LEN_LO, N x {W_HI, W_LO}, CHK.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam int LEN_W  = 16;
    localparam int LEN_BYTES = 2;

    localparam logic [BYTE_W-1:0] CHK_SEED = '0;

    // States that sit in the byte stream and can consume a byte.
    function automatic logic takes_byte(input state_t s);
        logic r;
        r = 1'b0;
        case (s)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: r = 1'b1;
            default:                                 r = 1'b0;
        endcase
        return r;
    endfunction

    // States from which a new load may be started.
    function automatic logic is_parked(input state_t s);
        logic r;
        r = 1'b0;
        case (s)
            IDLE, DONE, ERR: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = loader side, slave = byte producer / memory side.
interface inst_loader_if #(
    parameter int ADDR_W = 8
);
    import inst_loader_pkg::*;

    logic                byte_valid;
    logic [BYTE_W-1:0]   byte_data;
    logic                byte_ready;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/inst_loader.sv
// Fills instruction memory from a length-prefixed, XOR-checksummed byte stream,
// holding the CPU in reset for the whole load.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    inst_loader_if.master     bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MAX_WORDS);

    state_t state, next_state;

    logic [BYTE_W-1:0] len_hi;
    logic [LEN_W-1:0]  len;
    logic [BYTE_W-1:0] hi_byte;
    logic [BYTE_W-1:0] chk;

    logic              accept;
    logic              start_ok;
    logic [LEN_W-1:0]  len_new;
    logic              len_zero;
    logic              len_too_big;
    logic [LEN_W:0]    next_count;
    logic              last_word;
    logic              chk_match;

    assign bus.byte_ready = takes_byte(state);
    assign accept         = bus.byte_valid && bus.byte_ready;
    assign start_ok       = load_start && is_parked(state);

    assign len_new     = {len_hi, bus.byte_data};
    assign len_zero    = (len_new == '0);
    assign len_too_big = ({1'b0, len_new} > MAX_LEN);

    // word_count still holds the index of the word being accepted.
    assign next_count = (LEN_W+1)'(word_count) + (LEN_W+1)'(1);
    assign last_word  = (next_count == {1'b0, len});
    assign chk_match  = (bus.byte_data == chk);

    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign cpu_hold = !(state == IDLE || state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (load_start) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (accept) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (len_zero)         next_state = CHECK;
                    else if (len_too_big) next_state = ERR;
                    else                  next_state = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) next_state = DATA_LO;
            end
            DATA_LO: begin
                if (accept) next_state = last_word ? CHECK : DATA_HI;
            end
            CHECK: begin
                if (accept) next_state = chk_match ? DONE : ERR;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi        <= '0;
            len           <= '0;
            hi_byte       <= '0;
            chk           <= CHK_SEED;
            word_count    <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;

            if (start_ok) begin
                word_count <= '0;
                chk        <= CHK_SEED;
            end

            // The checksum byte itself is compared, not folded in.
            if (accept && state != CHECK) begin
                chk <= chk ^ bus.byte_data;
            end

            if (accept) begin
                case (state)
                    LEN_HI:  len_hi  <= bus.byte_data;
                    LEN_LO:  len     <= len_new;
                    DATA_HI: hi_byte <= bus.byte_data;
                    DATA_LO: begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= word_count[ADDR_W-1:0];
                        bus.mem_wdata <= {hi_byte, bus.byte_data};
                        word_count    <= word_count + (ADDR_W+1)'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: streams are parsed by a byte-level model
// that predicts every memory write, its cycle, and the final load status.
module tb_inst_loader;
    import inst_loader_pkg::*;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;
    localparam int HALF      = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_start;
    logic            cpu_hold;
    logic            done;
    logic            error;
    logic [ADDR_W:0] word_count;

    inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial forever #HALF clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] data;
        time         t;
    } wr_t;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [7:0]  stream[$];
    wr_t         exp_q[$];
    wr_t         w;
    bit          due;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every memory write must land exactly at its predicted negedge.
    always @(negedge clk) begin
        due = (exp_q.size() > 0) && (exp_q[0].t == $time);
        if (bus.mem_we || due) begin
            check("mem_we_timing", 32'(bus.mem_we), 32'(due));
            if (bus.mem_we && due) begin
                w = exp_q.pop_front();
                check("mem_addr", 32'(bus.mem_addr), w.addr);
                check("mem_wdata", 32'(bus.mem_wdata), 32'(w.data));
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 0);
        check({tag, "_we"},    32'(bus.mem_we), 0);
        check({tag, "_hold"},  32'(cpu_hold), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_addr"},  32'(bus.mem_addr), 0);
        check({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
        check({tag, "_wc"},    32'(word_count), 0);
    endtask

    task automatic make_stream(input int n, input bit bad);
        logic [7:0] x;
        logic [15:0] n16;
        n16 = n[15:0];
        stream.delete();
        stream.push_back(n16[15:8]);
        stream.push_back(n16[7:0]);
        if (n > MAX_WORDS) begin
            repeat (4) stream.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
            x = 8'h00;
            foreach (stream[i]) x ^= stream[i];
            if (bad) x ^= 8'(8'h01 << $urandom_range(7));
            stream.push_back(x);
        end
    endtask

    // stop_after > 0: feed only that many bytes and skip the end-of-load checks.
    task automatic run_load(input int gap_pct, input bit byte_with_start,
                            input bit noise, input int stop_after);
        int         n;
        bit         too_big;
        int         consume;
        int         limit;
        int         idx;
        int         budget;
        bit         good;
        bit         v;
        logic       rdy;
        logic [7:0] x;
        wr_t        e;

        n       = {stream[0], stream[1]};
        too_big = n > MAX_WORDS;
        consume = too_big ? 2 : 2 * n + 3;
        x = 8'h00;
        if (!too_big) for (int i = 0; i < consume - 1; i++) x ^= stream[i];
        good  = !too_big && (stream[consume-1] == x);
        limit = (stop_after > 0) ? stop_after : consume;

        @(negedge clk);
        load_start      = 1'b1;
        bus.byte_valid  = byte_with_start;
        bus.byte_data   = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        load_start     = 1'b0;
        bus.byte_valid = 1'b0;
        check("start_hold", 32'(cpu_hold), 1);
        check("start_done", 32'(done), 0);
        check("start_error", 32'(error), 0);
        check("start_wc", 32'(word_count), 0);

        idx    = 0;
        budget = 0;
        while (idx < limit && budget < 4000) begin
            v              = ($urandom_range(99) >= gap_pct);
            bus.byte_valid = v;
            bus.byte_data  = v ? stream[idx] : 8'($urandom);
            load_start     = noise && ($urandom_range(7) == 0);
            rdy            = bus.byte_ready;
            @(posedge clk);
            if (v && rdy) begin
                if (!too_big && idx >= 3 && idx <= 2 * n + 1 && idx % 2 == 1) begin
                    e.addr = (idx - 3) / 2;
                    e.data = {stream[idx-1], stream[idx]};
                    e.t    = $time + HALF;
                    exp_q.push_back(e);
                end
                idx++;
            end
            budget++;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        load_start     = 1'b0;
        check("bytes_consumed", idx, limit);
        if (stop_after > 0) return;

        // Trailing bytes must be refused once the load has ended.
        repeat (2) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'($urandom);
            check("ready_after_end", 32'(bus.byte_ready), 0);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        check("done", 32'(done), 32'(good));
        check("error", 32'(error), 32'(!good));
        check("cpu_hold", 32'(cpu_hold), 32'(!good));
        check("word_count", 32'(word_count), too_big ? 0 : n);
        check("writes_pending", exp_q.size(), 0);
    endtask

    initial begin
        reset          = 1'b1;
        load_start     = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;

        // Good load, then bad checksum on the same words.
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_load(0, 1'b0, 1'b0, 0);
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_load(0, 1'b0, 1'b0, 0);

        // Length 257 is rejected straight after LEN_LO.
        stream = '{8'h01, 8'h01, 8'h12, 8'h34, 8'h56};
        run_load(0, 1'b0, 1'b0, 0);

        // Zero length, with a byte offered alongside the start.
        stream = '{8'h00, 8'h00, 8'h00};
        run_load(0, 1'b1, 1'b0, 0);

        // Gapped version of the good load.
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_load(50, 1'b0, 1'b0, 0);

        // Reset after three data bytes, then a full load and a reload from DONE.
        run_load(0, 1'b0, 1'b0, 5);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check_cleared("midreset");
        run_load(0, 1'b0, 1'b0, 0);
        make_stream(3, 1'b0);
        run_load(20, 1'b0, 1'b0, 0);

        for (int t = 0; t < 12; t++) begin
            make_stream($urandom_range(0, 12), ($urandom_range(3) == 0));
            run_load($urandom_range(0, 50), 1'($urandom_range(1)), 1'b1, 0);
        end

        make_stream(MAX_WORDS, 1'b0);
        run_load(0, 1'b0, 1'b1, 0);
        make_stream(MAX_WORDS + 1, 1'b0);
        run_load(10, 1'b0, 1'b1, 0);
        make_stream(300, 1'b0);
        run_load(0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
